// File: rtl/spi_slave_fsm.sv
// rtl/spi_slave_fsm.sv - SPI slave transaction sequencer (optional abort_err via SPI_FSM_ERR_EN)
module spi_slave_fsm #(
    parameter int WORD_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_n,
    input  logic sclk_pos,
    input  logic sclk_neg,
    input  logic rw_bit,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic miso_buff,
    output logic busy
`ifdef SPI_FSM_ERR_EN
    ,
    output logic abort_err
`endif
);

    localparam int CW = $clog2(WORD_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SEND,
        WRITE_GET,
        WRITE_STORE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // Chip-select loss mid-transaction wins over any edge pulse, including the final one
        if (cs_n && state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!cs_n) begin
                        state_d = GET_ADDR;
                        cnt_d   = '0;
                    end
                end
                GET_ADDR: begin
                    if (sclk_pos) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST) state_d = GOT_ADDR;
                    end
                end
                GOT_ADDR: begin
                    state_d = rw_bit ? READ_LOAD : WRITE_GET;
                    cnt_d   = '0;
                end
                READ_LOAD: begin
                    state_d = READ_SEND;
                    cnt_d   = '0;
                end
                READ_SEND: begin
                    if (sclk_neg) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST) state_d = DONE;
                    end
                end
                WRITE_GET: begin
                    if (sclk_pos) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST) state_d = WRITE_STORE;
                    end
                end
                WRITE_STORE: state_d = DONE;
                DONE: begin
                    if (cs_n) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign addr_we   = (state_q == GOT_ADDR);
    assign sr_we     = (state_q == READ_LOAD);
    assign dm_we     = (state_q == WRITE_STORE);
    assign miso_buff = (state_q == READ_SEND);
    assign busy      = (state_q != IDLE) && (state_q != DONE);

`ifdef SPI_FSM_ERR_EN
    logic abort;
    assign abort = cs_n && (state_q != IDLE) && (state_q != DONE);

    always_ff @(posedge clk) begin
        if (reset)                         abort_err <= 1'b0;
        else if (abort)                    abort_err <= 1'b1;
        else if (state_q == IDLE && !cs_n) abort_err <= 1'b0;
    end
`endif

endmodule
